// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES datapath: initial key-add, NUM_ROUNDS rounds, then a done pulse.
// Optional feature: define AES_CTRL_ABORT_EN to add the abort input that cancels an in-flight block.
module aes_round_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key_valid,
`ifdef AES_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       ok_t,
  output logic       trigger,
  output logic       is_first,
  output logic       is_last,
  output logic [4:1] round_num,
  output logic       key_req,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       active;
  logic       abort_w;

`ifdef AES_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // A round only advances when its key is present; abort outranks key_valid.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT;
          round_d = 4'd0;
        end
      end
      INIT: begin
        if (abort_w) begin
          state_d = IDLE;
          round_d = 4'd0;
        end else if (key_valid) begin
          state_d = ROUND;
          round_d = 4'd1;
        end
      end
      ROUND: begin
        if (abort_w) begin
          state_d = IDLE;
          round_d = 4'd0;
        end else if (key_valid) begin
          if (round_q == LAST_ROUND) state_d = DONE;
          else                       round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        round_d = 4'd0;
      end
      default: begin
        state_d = IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  // Outputs decode the registered state only; key_valid/abort gate the firing strobe.
  assign active    = (state_q == INIT) || (state_q == ROUND);
  assign ok_t      = active;
  assign key_req   = active;
  assign busy      = active;
  assign trigger   = active && key_valid && !abort_w;
  assign is_first  = (state_q == INIT);
  assign is_last   = (state_q == ROUND) && (round_q == LAST_ROUND);
  assign done      = (state_q == DONE);
  assign round_num = round_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: a vector table for the nominal 10-round block plus
// hand-written stall, back-to-back, reset, 14-round and (AES_CTRL_ABORT_EN) abort sequences.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, key_valid;
`ifdef AES_CTRL_ABORT_EN
  logic abort, abort_next;
`endif

  logic       ok_t, trigger, is_first, is_last, key_req, busy, done;
  logic [4:1] round_num;
  logic [1:0] dbg_state;

  logic       ok_t14, trigger14, is_first14, is_last14, key_req14, busy14, done14;
  logic [4:1] round_num14;
  logic [1:0] dbg_state14;

  aes_round_ctrl #(.NUM_ROUNDS(10)) u_dut (
    .clk(clk), .rst(rst), .start(start), .key_valid(key_valid),
`ifdef AES_CTRL_ABORT_EN
    .abort(abort),
`endif
    .ok_t(ok_t), .trigger(trigger), .is_first(is_first), .is_last(is_last),
    .round_num(round_num), .key_req(key_req), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  aes_round_ctrl #(.NUM_ROUNDS(14)) u_dut14 (
    .clk(clk), .rst(rst), .start(start), .key_valid(key_valid),
`ifdef AES_CTRL_ABORT_EN
    .abort(abort),
`endif
    .ok_t(ok_t14), .trigger(trigger14), .is_first(is_first14), .is_last(is_last14),
    .round_num(round_num14), .key_req(key_req14), .busy(busy14), .done(done14),
    .dbg_state(dbg_state14)
  );

  // Packed view: {state[1:0], ok_t, trigger, is_first, is_last, round_num[3:0], key_req, busy, done}
  typedef struct {
    logic        start;
    logic        key_valid;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[14];
  int   vectors = 0;
  int   fails   = 0;

  function automatic logic [12:0] act10();
    return {dbg_state, ok_t, trigger, is_first, is_last, round_num, key_req, busy, done};
  endfunction

  function automatic vec_t mk(input logic s, input logic k, input logic [1:0] st,
                              input logic [3:0] flags, input logic [3:0] rn, input logic [2:0] tail);
    vec_t v;
    v.start     = s;
    v.key_valid = k;
    v.exp       = {st, flags, rn, tail};
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change at the falling edge; outputs are checked 1 ns later, well before the next rise.
  task automatic step(input logic st, input logic kv);
    @(negedge clk);
    start     = st;
    key_valid = kv;
`ifdef AES_CTRL_ABORT_EN
    abort     = abort_next;
`endif
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    start     = 1'b0;
    key_valid = 1'b0;
`ifdef AES_CTRL_ABORT_EN
    abort      = 1'b0;
    abort_next = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Nominal 10-round block, key always present, start pulsed in cycle 0.
    vecs[0]  = mk(1, 1, 2'd0, 4'b0000, 4'd0,  3'b000);
    vecs[1]  = mk(0, 1, 2'd1, 4'b1110, 4'd0,  3'b110);
    vecs[2]  = mk(0, 1, 2'd2, 4'b1100, 4'd1,  3'b110);
    vecs[3]  = mk(0, 1, 2'd2, 4'b1100, 4'd2,  3'b110);
    vecs[4]  = mk(0, 1, 2'd2, 4'b1100, 4'd3,  3'b110);
    vecs[5]  = mk(0, 1, 2'd2, 4'b1100, 4'd4,  3'b110);
    vecs[6]  = mk(0, 1, 2'd2, 4'b1100, 4'd5,  3'b110);
    vecs[7]  = mk(0, 1, 2'd2, 4'b1100, 4'd6,  3'b110);
    vecs[8]  = mk(0, 1, 2'd2, 4'b1100, 4'd7,  3'b110);
    vecs[9]  = mk(0, 1, 2'd2, 4'b1100, 4'd8,  3'b110);
    vecs[10] = mk(0, 1, 2'd2, 4'b1100, 4'd9,  3'b110);
    vecs[11] = mk(0, 1, 2'd2, 4'b1101, 4'd10, 3'b110);
    vecs[12] = mk(0, 1, 2'd3, 4'b0000, 4'd10, 3'b001);
    vecs[13] = mk(0, 1, 2'd0, 4'b0000, 4'd0,  3'b000);

    rst = 1'b1;
    start = 1'b0;
    key_valid = 1'b0;
`ifdef AES_CTRL_ABORT_EN
    abort = 1'b0;
    abort_next = 1'b0;
`endif
    #1;
    chk("reset_state", 16'(act10()), 16'h0000);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].start, vecs[i].key_valid);
      chk($sformatf("nominal_c%0d", i), 16'(act10()), 16'(vecs[i].exp));
    end

    // Key missing in cycles 4..6: round 3 holds, no firing, done slips to cycle 15.
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      step(c == 0, !(c >= 4 && c <= 6));
      if (c >= 4 && c <= 6)
        chk($sformatf("stall_hold_c%0d", c), {11'd0, round_num, trigger}, {11'd0, 4'd3, 1'b0});
      chk($sformatf("stall_done_c%0d", c), 16'(done), 16'(c == 15));
    end

    // start held high: one idle cycle between blocks, second done in cycle 25.
    do_reset();
    for (int c = 0; c <= 26; c++) begin
      step(c <= 15, 1'b1);
      chk($sformatf("b2b_done_c%0d", c), 16'(done), 16'(c == 12 || c == 25));
      if (c == 13) chk("b2b_idle_gap", {13'd0, busy, dbg_state}, 16'h0000);
      if (c == 14) chk("b2b_second_init", {14'd0, is_first, busy}, 16'h0003);
    end

    // Asynchronous reset in the middle of round 5.
    do_reset();
    for (int c = 0; c <= 6; c++) step(c == 0, 1'b1);
    chk("rst_pre_round5", 16'(round_num), 16'd5);
    rst = 1'b1;
    #1;
    chk("rst_async_clear", 16'(act10()), 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 14; c++) begin
      step(1'b0, 1'b1);
      chk($sformatf("rst_no_done_c%0d", c), {14'd0, busy, done}, 16'h0000);
    end
    for (int c = 0; c <= 13; c++) begin
      step(c == 0, 1'b1);
      chk($sformatf("rst_restart_c%0d", c), 16'(done), 16'(c == 12));
    end

    // 14-round instance: is_last in cycle 15, done in cycle 16.
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      step(c == 0, 1'b1);
      chk($sformatf("r14_c%0d", c), {13'd0, busy14, is_last14, done14},
          {13'd0, 1'(c >= 1 && c <= 15), 1'(c == 15), 1'(c == 16)});
    end

`ifdef AES_CTRL_ABORT_EN
    // Abort during round 7: no firing that cycle, idle next cycle, never done.
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      abort_next = (c == 8);
      step(c == 0, 1'b1);
      if (c == 8) chk("abort_cycle", {11'd0, round_num, trigger}, {11'd0, 4'd7, 1'b0});
      if (c == 9) chk("abort_idle", {9'd0, dbg_state, busy, round_num}, 16'h0000);
      chk($sformatf("abort_no_done_c%0d", c), 16'(done), 16'h0000);
    end
    abort_next = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, meaning the number of cipher rounds after the initial key-add (legal values 10, 12, 14).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin one block encryption; sampled only in IDLE.
REQ-005 key_valid  input  1  round key for the current round is present on the key path.
REQ-006 abort  input  1  cancel an in-flight block (present only when AES_CTRL_ABORT_EN is defined).
REQ-007 ok_t  output  1  datapath valid qualifier driven to the substitution stage.
REQ-008 trigger  output  1  one-cycle strobe: the current round fires this cycle.
REQ-009 is_first  output  1  round 0 active; the datapath bypasses substitution.
REQ-010 is_last  output  1  final round active; the datapath skips the column mix.
REQ-011 round_num  output  [4:1]  index of the current round, 0..NUM_ROUNDS.
REQ-012 key_req  output  1  request for the round key of round_num.
REQ-013 busy  output  1  block in flight.
REQ-014 done  output  1  one-cycle pulse marking completion of the block.

Function
REQ-015 The FSM SHALL have states IDLE, INIT, ROUND and DONE, encoded in 2 bits.
REQ-016 IDLE with start=1 SHALL move to INIT on the next edge and set round_num=0.
- All other inputs are ignored in IDLE.
REQ-017 In INIT, the SHALL assert ok_t=1, is_first=1 and key_req=1, and assert trigger = key_valid.
REQ-018 INIT with key_valid=1 SHALL move to ROUND with round_num=1; with key_valid=0 it SHALL hold (stall).
REQ-019 In ROUND, the block SHALL assert ok_t=1, is_first=0, key_req=1 and trigger=key_valid, and assert is_last=1 iff round_num==NUM_ROUNDS.
REQ-020 ROUND with key_valid=1 SHALL advance as follows:
- round_num<NUM_ROUNDS: increment round_num.
- round_num==NUM_ROUNDS: move to DONE.
- key_valid=0: hold every output, with trigger=0.
REQ-021 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE with round_num=0.
- start is ignored in DONE.
REQ-022 busy SHALL be 1 in INIT and ROUND, and 0 in IDLE and DONE.
REQ-023 trigger SHALL never be 1 while ok_t=0.
REQ-024 With key_valid held high, latency SHALL be as follows:
- start sampled at edge 0 gives done=1 in cycle NUM_ROUNDS+2.
- NUM_ROUNDS+1 trigger pulses occur in total.
REQ-025 Every output SHALL be a registered state decode; none is combinationally dependent on start.

Reset
REQ-026 rst=1 SHALL immediately force IDLE and set all outputs to 0, including round_num=4'd0, independent of clk.
REQ-027 Reset asserted mid-block SHALL discard the block with no done pulse, and operation SHALL resume only on a new start after rst deasserts.

Configuration
REQ-028 With macro AES_CTRL_ABORT_EN defined:
- The abort port exists.
- abort=1 in INIT or ROUND returns to IDLE on the next edge, with round_num=0, no done pulse, and trigger=0 in the abort cycle.
- abort is ignored in IDLE and DONE.
REQ-029 Without AES_CTRL_ABORT_EN, the abort port and its logic SHALL be absent, and a block always runs to DONE unless reset.

Verification
REQ-030 NUM_ROUNDS=10, key_valid=1, start pulse at cycle 0 -> trigger high cycles 1..11; is_first only in cycle 1; is_last only in cycle 11; done in cycle 12; busy cycles 1..11.
REQ-031 key_valid low in cycles 4..6 of the REQ-030 run -> round_num holds at 3, trigger=0 in those cycles, done moves to cycle 15.
REQ-032 start held high continuously -> done pulses in cycle 12, next block's INIT in cycle 14 (IDLE in cycle 13), no overlap.
REQ-033 rst asserted asynchronously mid-cycle at round_num=5 -> all outputs 0 before the next edge, no done pulse, and a new start after reset completes normally.
REQ-034 With AES_CTRL_ABORT_EN defined, abort at round_num=7 -> IDLE next cycle, done never asserted; NUM_ROUNDS=14 run -> done in cycle 16, is_last in cycle 15.
